// File: rtl/mp_adder_pkg.sv
// Shared constants for the multi-precision add/subtract sequencer.
// State encodings, default geometry and counter sizing.
package mp_adder_pkg;

    localparam int MP_WIDTH_DEF  = 32;
    localparam int MP_NWORDS_DEF = 4;

    localparam logic [1:0] MP_IDLE = 2'd0;
    localparam logic [1:0] MP_RUN  = 2'd1;
    localparam logic [1:0] MP_DONE = 2'd2;

    // Word counter width; a single-word build still needs one bit.
    function automatic int mp_cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cla_adder.sv
// WIDTH-bit carry-lookahead adder with group propagate/generate.
// Carry chain is evaluated bit-serially inside one combinational block.
module cla_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic             Carry_i,
    output logic [WIDTH-1:0] Sum_o,
    output logic             Carry_o,
    output logic             Propagate_o,
    output logic             Generate_o
);

    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_g;
    logic             w_c;
    logic             w_gg;

    assign w_p = A_i ^ B_i;
    assign w_g = A_i & B_i;

    always_comb begin
        Sum_o = '0;
        w_c   = Carry_i;
        w_gg  = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            Sum_o[i] = w_p[i] ^ w_c;
            w_c      = w_g[i] | (w_p[i] & w_c);
            w_gg     = w_g[i] | (w_p[i] & w_gg);
        end
    end

    assign Carry_o     = w_c;
    assign Propagate_o = &w_p;
    assign Generate_o  = w_gg;

endmodule

// File: rtl/mp_adder_ctrl.sv
// Multi-precision add/subtract sequencer: one narrow adder, one word per
// cycle, LS word first, carry registered between words.
module mp_adder_ctrl
    import mp_adder_pkg::*;
#(
    parameter int WIDTH  = MP_WIDTH_DEF,
    parameter int NWORDS = MP_NWORDS_DEF
) (
    input  logic                     Clock_i,
    input  logic                     Reset_i,
    input  logic                     Start_i,
    input  logic                     Sub_i,
    input  logic                     Carry_i,
    input  logic [NWORDS*WIDTH-1:0]  Number1_i,
    input  logic [NWORDS*WIDTH-1:0]  Number2_i,
    output logic                     Busy_o,
    output logic                     Done_o,
    output logic [NWORDS*WIDTH-1:0]  Result_o,
    output logic                     Carry_o,
    output logic                     Overflow_o
);

    localparam int TW = NWORDS * WIDTH;
    localparam int CW = mp_cnt_width(NWORDS);
    localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [TW-1:0] r_a;
    logic [TW-1:0] r_b;
    logic [TW-1:0] r_res_sr;
    logic          r_carry;
    logic [TW-1:0] r_result;
    logic          r_carry_o;
    logic          r_ovf;

    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_last;
    logic             w_ovf;
    logic [TW-1:0]    w_res_next;
    logic             w_unused_prop;
    logic             w_unused_gen;

    cla_adder #(.WIDTH(WIDTH)) u_cla (
        .A_i         (r_a[WIDTH-1:0]),
        .B_i         (r_b[WIDTH-1:0]),
        .Carry_i     (r_carry),
        .Sum_o       (w_sum),
        .Carry_o     (w_cout),
        .Propagate_o (w_unused_prop),
        .Generate_o  (w_unused_gen)
    );

    // New word enters at the top so the LS word ends up at the bottom.
    generate
        if (NWORDS == 1) begin : g_one
            assign w_res_next = w_sum;
        end else begin : g_multi
            assign w_res_next = {w_sum, r_res_sr[TW-1:WIDTH]};
        end
    endgenerate

    assign w_last = (r_cnt == LAST);
    assign w_ovf  = (r_a[WIDTH-1] == r_b[WIDTH-1])
                  & (w_sum[WIDTH-1] != r_a[WIDTH-1]);

    always_ff @(posedge Clock_i) begin
        if (Reset_i) begin
            r_state   <= MP_IDLE;
            r_cnt     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_res_sr  <= '0;
            r_carry   <= 1'b0;
            r_result  <= '0;
            r_carry_o <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                MP_IDLE: begin
                    if (Start_i) begin
                        r_a     <= Number1_i;
                        r_b     <= Sub_i ? ~Number2_i : Number2_i;
                        r_carry <= Sub_i | Carry_i;
                        r_cnt   <= '0;
                        r_state <= MP_RUN;
                    end
                end
                MP_RUN: begin
                    r_a      <= r_a >> WIDTH;
                    r_b      <= r_b >> WIDTH;
                    r_res_sr <= w_res_next;
                    r_carry  <= w_cout;
                    if (w_last) begin
                        r_result  <= w_res_next;
                        r_carry_o <= w_cout;
                        r_ovf     <= w_ovf;
                        r_state   <= MP_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                MP_DONE: r_state <= MP_IDLE;
                default: r_state <= MP_IDLE;
            endcase
        end
    end

    assign Busy_o     = (r_state == MP_RUN) | (r_state == MP_DONE);
    assign Done_o     = (r_state == MP_DONE);
    assign Result_o   = r_result;
    assign Carry_o    = r_carry_o;
    assign Overflow_o = r_ovf;

endmodule

// File: tb/tb_mp_adder_ctrl.sv
// Bench for mp_adder_ctrl: a 2-word and a 1-word instance driven together
// and compared every cycle against an arithmetic reference.
module tb_mp_adder_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start1 = 1'b0;
    logic        start2 = 1'b0;
    logic        sub = 1'b0;
    logic        cin = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;

    logic        busy1, done1, co1, ov1;
    logic [31:0] res1;
    logic        busy2, done2, co2, ov2;
    logic [63:0] res2;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mp_adder_ctrl #(.WIDTH(32), .NWORDS(2)) u_dut2 (
        .Clock_i(clk), .Reset_i(rst), .Start_i(start2), .Sub_i(sub),
        .Carry_i(cin), .Number1_i(a), .Number2_i(b), .Busy_o(busy2),
        .Done_o(done2), .Result_o(res2), .Carry_o(co2), .Overflow_o(ov2)
    );

    mp_adder_ctrl #(.WIDTH(32), .NWORDS(1)) u_dut1 (
        .Clock_i(clk), .Reset_i(rst), .Start_i(start1), .Sub_i(sub),
        .Carry_i(cin), .Number1_i(a[31:0]), .Number2_i(b[31:0]),
        .Busy_o(busy1), .Done_o(done1), .Result_o(res1), .Carry_o(co1),
        .Overflow_o(ov1)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Full-width arithmetic: {carry, A + B' + cin} over w bits.
    function automatic void calc(input int w, input logic [63:0] x,
                                 input logic [63:0] y, input logic s,
                                 input logic c, output logic [63:0] r,
                                 output logic co, output logic ov);
        logic [64:0] mask, bx, sum;
        mask = (65'd1 << w) - 65'd1;
        bx   = (s ? ~{1'b0, y} : {1'b0, y}) & mask;
        sum  = ({1'b0, x} & mask) + bx + 65'(s | c);
        r    = sum[63:0] & mask[63:0];
        co   = sum[w];
        ov   = (x[w-1] == bx[w-1]) && (r[w-1] != x[w-1]);
    endfunction

    // Reference: 0 idle, 1 working (m_left cycles to go), 2 done cycle.
    int          m_ph[2];
    int          m_left[2];
    logic [63:0] m_res[2], m_pres[2];
    logic        m_co[2], m_pco[2], m_ov[2], m_pov[2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_ph[i] = 0;
                m_res[i] = '0;
                m_co[i] = 1'b0;
                m_ov[i] = 1'b0;
            end else if (m_ph[i] == 0) begin
                if ((i == 0) ? start2 : start1) begin
                    calc((i == 0) ? 64 : 32, a, b, sub, cin,
                         m_pres[i], m_pco[i], m_pov[i]);
                    m_ph[i] = 1;
                    m_left[i] = (i == 0) ? 2 : 1;
                end
            end else if (m_ph[i] == 1) begin
                m_left[i]--;
                if (m_left[i] == 0) begin
                    m_res[i] = m_pres[i];
                    m_co[i] = m_pco[i];
                    m_ov[i] = m_pov[i];
                    m_ph[i] = 2;
                end
            end else begin
                m_ph[i] = 0;
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (chk_en) begin
            chk("busy2", 64'(busy2), 64'(m_ph[0] != 0));
            chk("done2", 64'(done2), 64'(m_ph[0] == 2));
            chk("res2", res2, m_res[0]);
            chk("co2", 64'(co2), 64'(m_co[0]));
            chk("ov2", 64'(ov2), 64'(m_ov[0]));
            chk("busy1", 64'(busy1), 64'(m_ph[1] != 0));
            chk("done1", 64'(done1), 64'(m_ph[1] == 2));
            chk("res1", 64'(res1), m_res[1]);
            chk("co1", 64'(co1), 64'(m_co[1]));
            chk("ov1", 64'(ov1), 64'(m_ov[1]));
        end
    end

    task automatic run(input logic [63:0] x, input logic [63:0] y,
                       input logic s, input logic c,
                       output int lat2, output int lat1);
        int k;
        @(negedge clk);
        a = x; b = y; sub = s; cin = c;
        start1 = 1'b1; start2 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; start2 = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        sub = 1'($urandom); cin = 1'($urandom);
        lat1 = 0; lat2 = 0; k = 1;
        while (k < 20 && lat2 == 0) begin
            if (done1 && lat1 == 0) lat1 = k;
            if (done2) lat2 = k;
            if (lat2 == 0) begin
                @(negedge clk);
                k++;
            end
        end
        if (lat2 == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL done2_timeout: got none expected pulse");
        end
        @(negedge clk);
    endtask

    initial begin
        int l2, l1, nd;
        logic [63:0] x, y;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 64'(busy2), 64'd0);
        chk("rst_res", res2, 64'd0);
        chk("rst_done", 64'(done2), 64'd0);

        run(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0, l2, l1);
        chk("t1_res", res2, 64'h0000_0001_0000_0000);
        chk("t1_co", 64'(co2), 64'd0);
        chk("t1_ov", 64'(ov2), 64'd0);
        chk("t1_lat", 64'(l2), 64'd3);

        run(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1, l2, l1);
        chk("t2_res", res2, 64'h0);
        chk("t2_co", 64'(co2), 64'd1);
        chk("t2_ov", 64'(ov2), 64'd0);

        run(64'h0, 64'h1, 1'b1, 1'b0, l2, l1);
        chk("t3_res", res2, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t3_co", 64'(co2), 64'd0);
        chk("t3_ov", 64'(ov2), 64'd0);
        run(64'h5, 64'h3, 1'b1, 1'b0, l2, l1);
        chk("t3b_res", res2, 64'h2);
        chk("t3b_co", 64'(co2), 64'd1);

        run(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, l2, l1);
        chk("t4_res", res2, 64'h8000_0000_0000_0000);
        chk("t4_ov", 64'(ov2), 64'd1);
        chk("t4_co", 64'(co2), 64'd0);

        run(64'h0000_0000_FFFF_FFFF, 64'h0, 1'b0, 1'b1, l2, l1);
        chk("t6_res1", 64'(res1), 64'h0);
        chk("t6_co1", 64'(co1), 64'd1);
        chk("t6_lat1", 64'(l1), 64'd2);

        // Start during RUN must not disturb the operation in flight.
        @(negedge clk);
        a = 64'd5; b = 64'd3; sub = 1'b0; cin = 1'b0; start2 = 1'b1;
        @(negedge clk);
        a = 64'h1234; b = 64'h1234; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            if (done2) nd++;
            @(negedge clk);
        end
        chk("t5_res", res2, 64'd8);
        chk("t5_ndone", 64'(nd), 64'd1);

        // Reset mid-RUN drops the operation.
        start2 = 1'b1; a = 64'd9; b = 64'd9;
        @(negedge clk);
        start2 = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_busy", 64'(busy2), 64'd0);
        chk("t5_rres", res2, 64'd0);
        nd = 0;
        for (int i = 0; i < 5; i++) begin
            if (done2) nd++;
            @(negedge clk);
        end
        chk("t5_nodone", 64'(nd), 64'd0);

        // Reset and start together: reset wins.
        rst = 1'b1; start2 = 1'b1;
        @(negedge clk);
        rst = 1'b0; start2 = 1'b0;
        chk("rs_busy", 64'(busy2), 64'd0);

        for (int i = 0; i < 40; i++) begin
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            if (i % 8 == 1) x = 64'hFFFF_FFFF_FFFF_FFFF;
            if (i % 8 == 2) y = 64'h8000_0000_0000_0000;
            run(x, y, 1'($urandom), 1'($urandom), l2, l1);
        end

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
